// File: rtl/rmii_tx_framer_pkg.sv
// rmii_pkg: shared types and constants for the RMII transmit framer.
//   state_t    - framer FSM states
//   CRC_INIT   - CRC-32 preset value
//   CRC_POLY   - reflected CRC-32 polynomial
//   SFD_DIBITS - last four preamble dibits in wire order (first dibit in [7:6])
//   PRE_DIBIT  - repeated preamble dibit (0x55 sent LSB first)
//   pre_dibit  - dibit to drive for preamble position idx of total
package rmii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PAYLOAD,
        PAD,
        FCS,
        IPG
    } state_t;

    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [7:0]  SFD_DIBITS = {2'b01, 2'b01, 2'b01, 2'b11};
    localparam logic [1:0]  PRE_DIBIT  = 2'b01;

    // The final four positions carry the SFD byte 0xD5; everything before
    // it is the 0x55 pattern.
    function automatic logic [1:0] pre_dibit(input logic [7:0] idx,
                                             input logic [7:0] total);
        logic [1:0] j;
        if (idx < total - 8'd4) begin
            return PRE_DIBIT;
        end
        j = 2'(idx - (total - 8'd4));
        return SFD_DIBITS[{~j, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/rmii_tx_framer_crc32_dibit.sv
// crc32_dibit: combinational next-state of a reflected CRC-32 for one dibit.
// Bit dibit[0] is folded in first, then dibit[1] (wire order).
//   crc_in  [31:0] - current CRC register
//   dibit   [1:0]  - data dibit
//   crc_out [31:0] - CRC after both bits
module crc32_dibit
    import rmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: frames an upstream dibit stream for the RMII TX pins.
// Sends preamble+SFD, forwards payload dibits while computing CRC-32,
// appends the FCS and holds the inter-packet gap before the next frame.
// Optional macro RMII_TX_PAD_EN: zero-pad short payloads to MIN_DIBITS.
// Ports:
//   clk      - 50 MHz RMII reference clock
//   rst      - asynchronous reset, active low
//   start    - frame request pulse (latched if it arrives during IPG)
//   axiiv    - upstream dibit valid
//   axiid    - upstream dibit, [0] first on wire
//   stall    - 1 = upstream holds, 0 = upstream streams payload
//   eth_txen - RMII TX_EN
//   eth_txd  - RMII TXD, [0] first on wire
//   busy     - high whenever the framer is not idle
//   done     - one-cycle pulse with the last FCS dibit
module rmii_tx_framer
    import rmii_pkg::*;
#(
    parameter int unsigned PRE_DIBITS = 32,
    parameter int unsigned IPG_DIBITS = 48,
    parameter int unsigned STALL_LEAD = 1,
    parameter int unsigned MIN_DIBITS = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       stall,
    output logic       eth_txen,
    output logic [1:0] eth_txd,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] PRE_LEN  = 8'(PRE_DIBITS);
    localparam logic [7:0] PRE_LAST = 8'(PRE_DIBITS - 1);
    localparam logic [7:0] STALL_AT = 8'(PRE_DIBITS - 1 - STALL_LEAD);
    localparam logic [7:0] IPG_LAST = 8'(IPG_DIBITS - 1);
    localparam logic [7:0] FCS_LAST = 8'd15;
`ifdef RMII_TX_PAD_EN
    localparam logic [15:0] MIN_CNT = 16'(MIN_DIBITS);
`endif

    if (STALL_LEAD >= PRE_DIBITS || PRE_DIBITS < 4 || PRE_DIBITS > 255 ||
        IPG_DIBITS < 1 || IPG_DIBITS > 255 ||
        MIN_DIBITS < 1 || MIN_DIBITS > 65535) begin : g_bad_params
        $error("rmii_tx_framer: parameter out of range");
    end

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] pay_cnt;
    logic [31:0] crc;
    logic [31:0] fcs_sr;
    logic        pending;

    logic [1:0]  crc_din;
    logic [31:0] crc_next;
    logic [31:0] fcs_now;

    // Pad dibits are zero, so the single CRC instance only sees axiid
    // while real payload is being accepted.
    always_comb begin
        crc_din = '0;
        if (state == PAYLOAD && axiiv) begin
            crc_din = axiid;
        end
        fcs_now = ~crc;
    end

    crc32_dibit u_crc (
        .crc_in (crc),
        .dibit  (crc_din),
        .crc_out(crc_next)
    );

    // The payload->FCS transition edge already drives FCS dibit 0 so that
    // TX_EN stays contiguous; the FCS state then supplies dibits 1..15
    // from the frozen shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pay_cnt  <= '0;
            crc      <= CRC_INIT;
            fcs_sr   <= '0;
            pending  <= 1'b0;
            stall    <= 1'b1;
            eth_txen <= 1'b0;
            eth_txd  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    eth_txen <= 1'b0;
                    eth_txd  <= '0;
                    stall    <= 1'b1;
                    if (start) begin
                        state   <= PRE;
                        cnt     <= '0;
                        pay_cnt <= '0;
                        crc     <= CRC_INIT;
                        busy    <= 1'b1;
                    end
                end

                PRE: begin
                    eth_txen <= 1'b1;
                    eth_txd  <= pre_dibit(cnt, PRE_LEN);
                    if (cnt == STALL_AT) begin
                        stall <= 1'b0;
                    end
                    if (cnt == PRE_LAST) begin
                        state <= PAYLOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                PAYLOAD: begin
                    eth_txen <= 1'b1;
                    if (axiiv) begin
                        eth_txd <= axiid;
                        crc     <= crc_next;
                        if (pay_cnt != '1) begin
                            pay_cnt <= pay_cnt + 16'd1;
                        end
                    end else begin
                        stall <= 1'b1;
`ifdef RMII_TX_PAD_EN
                        if (pay_cnt < MIN_CNT) begin
                            eth_txd <= '0;
                            crc     <= crc_next;
                            pay_cnt <= pay_cnt + 16'd1;
                            state   <= PAD;
                        end else begin
                            eth_txd <= fcs_now[1:0];
                            fcs_sr  <= {2'b00, fcs_now[31:2]};
                            cnt     <= 8'd1;
                            state   <= FCS;
                        end
`else
                        eth_txd <= fcs_now[1:0];
                        fcs_sr  <= {2'b00, fcs_now[31:2]};
                        cnt     <= 8'd1;
                        state   <= FCS;
`endif
                    end
                end

`ifdef RMII_TX_PAD_EN
                PAD: begin
                    eth_txen <= 1'b1;
                    if (pay_cnt < MIN_CNT) begin
                        eth_txd <= '0;
                        crc     <= crc_next;
                        pay_cnt <= pay_cnt + 16'd1;
                    end else begin
                        eth_txd <= fcs_now[1:0];
                        fcs_sr  <= {2'b00, fcs_now[31:2]};
                        cnt     <= 8'd1;
                        state   <= FCS;
                    end
                end
`endif

                FCS: begin
                    eth_txen <= 1'b1;
                    eth_txd  <= fcs_sr[1:0];
                    fcs_sr   <= fcs_sr >> 2;
                    if (cnt == FCS_LAST) begin
                        done  <= 1'b1;
                        state <= IPG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                IPG: begin
                    eth_txen <= 1'b0;
                    eth_txd  <= '0;
                    stall    <= 1'b1;
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (cnt == IPG_LAST) begin
                        cnt     <= '0;
                        pending <= 1'b0;
                        if (start || pending) begin
                            state   <= PRE;
                            pay_cnt <= '0;
                            crc     <= CRC_INIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_tx_framer.sv
module tb_rmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic       stall;
    logic       eth_txen;
    logic [1:0] eth_txd;
    logic       busy;
    logic       done;

`ifdef RMII_TX_PAD_EN
    localparam int  PAD_MIN   = 240;
    localparam bit  FCS_KNOWN = 1'b0;
`else
    localparam int  PAD_MIN   = 0;
    localparam bit  FCS_KNOWN = 1'b1;
`endif

    rmii_tx_framer #(
        .PRE_DIBITS(32),
        .IPG_DIBITS(48),
        .STALL_LEAD(1),
        .MIN_DIBITS(240)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .axiiv   (axiiv),
        .axiid   (axiid),
        .stall   (stall),
        .eth_txen(eth_txen),
        .eth_txd (eth_txd),
        .busy    (busy),
        .done    (done)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] pay[$];
    logic [1:0] wire_q[$];
    int         stall_low_at;
    int         done_pos;
    bit         seen_done;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_capture();
        wire_q.delete();
        stall_low_at = -1;
        done_pos     = -1;
        seen_done    = 1'b0;
    endtask

    // Registered upstream model: it streams the next dibit after any edge
    // at which it saw stall low, until the payload is exhausted.
    task automatic capture(input int ndib, input int max_cyc, input int start_at,
                           input bit expect_done);
        int  idx;
        logic prev_stall;
        idx = 0;
        for (int cyc = 0; cyc < max_cyc && !seen_done; cyc++) begin
            start      = (cyc == start_at);
            prev_stall = stall;
            tick();
            if (eth_txen) wire_q.push_back(eth_txd);
            if (done) begin
                seen_done = 1'b1;
                done_pos  = wire_q.size() - 1;
            end
            if (!stall && stall_low_at < 0) stall_low_at = wire_q.size();
            if (!prev_stall && idx < ndib) begin
                axiiv = 1'b1;
                axiid = pay[idx];
                idx++;
            end else begin
                axiiv = 1'b0;
                axiid = 2'b00;
            end
        end
        start = 1'b0;
        axiiv = 1'b0;
        if (expect_done && !seen_done) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int ndib, input int start_at);
        begin_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("txen_lag", 64'(eth_txen), 64'd0);
        check_eq("busy_rise", 64'(busy), 64'd1);
        capture(ndib, 2000, start_at, 1'b1);
    endtask

    task automatic check_frame(input string pfx, input int ndib,
                               input logic [31:0] exp_fcs);
        int          eff;
        int          errs;
        logic [63:0] pre_obs;
        logic [31:0] fcs_obs;
        eff = (ndib < PAD_MIN) ? PAD_MIN : ndib;
        check_eq({pfx, "_len"}, 64'(wire_q.size()), 64'(32 + eff + 16));
        pre_obs = '0;
        for (int i = 0; i < 32; i++) pre_obs[2*i +: 2] = wire_q[i];
        check_eq({pfx, "_preamble"}, pre_obs, 64'hD555_5555_5555_5555);
        check_eq({pfx, "_stall_low"}, 64'(stall_low_at), 64'd31);
        errs = 0;
        for (int i = 0; i < eff; i++) begin
            if (wire_q[32 + i] !== ((i < ndib) ? pay[i] : 2'b00)) errs++;
        end
        check_eq({pfx, "_payload_errs"}, 64'(errs), 64'd0);
        check_eq({pfx, "_done_pos"}, 64'(done_pos), 64'(wire_q.size() - 1));
        if (FCS_KNOWN) begin
            fcs_obs = '0;
            for (int k = 0; k < 16; k++) fcs_obs[2*k +: 2] = wire_q[32 + eff + k];
            check_eq({pfx, "_fcs"}, 64'(fcs_obs), 64'(exp_fcs));
            check_eq({pfx, "_fcs_dibit0"}, 64'(wire_q[32 + eff]), 64'(exp_fcs[1:0]));
        end
    endtask

    initial begin
        logic [7:0] msg [9];
        int         low_cnt;
        int         hi_cnt;
        bit         relaunched;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int b = 0; b < 9; b++) begin
            for (int d = 0; d < 4; d++) pay.push_back(msg[b][2*d +: 2]);
        end

        // Reset state
        tick();
        tick();
        check_eq("rst_stall", 64'(stall), 64'd1);
        check_eq("rst_txen", 64'(eth_txen), 64'd0);
        check_eq("rst_txd", 64'(eth_txd), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();

        // "123456789" frame, FCS 0xCBF43926
        send_frame(36, -1);
        check_frame("f1", 36, 32'hCBF4_3926);

        // Gap length, with a start request in IPG cycle 10
        low_cnt    = 0;
        relaunched = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            start = (i == 10);
            tick();
            if (eth_txen) begin
                relaunched = 1'b1;
                break;
            end
            low_cnt++;
        end
        start = 1'b0;
        check_eq("ipg_low_cycles", 64'(low_cnt), 64'd48);
        check_eq("ipg_pending_launch", 64'(relaunched), 64'd1);

        // Launched frame carries an empty payload
        begin_capture();
        if (eth_txen) wire_q.push_back(eth_txd);
        capture(0, 2000, -1, 1'b1);
        check_frame("empty", 0, 32'h0000_0000);

        low_cnt = 0;
        while (busy && low_cnt < 200) begin
            tick();
            low_cnt++;
        end
        check_eq("idle_after_empty", 64'(busy), 64'd0);

        // Reset in the middle of the payload
        begin_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(36, 45, -1, 1'b0);
        check_eq("pre_reset_in_payload", 64'(wire_q.size()), 64'd45);
        #3;
        rst = 1'b0;
        #1;
        check_eq("midrst_txen", 64'(eth_txen), 64'd0);
        check_eq("midrst_stall", 64'(stall), 64'd1);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        send_frame(36, -1);
        check_frame("after_rst", 36, 32'hCBF4_3926);

        // Start during payload is ignored and no second frame follows
        low_cnt = 0;
        while (busy && low_cnt < 200) begin
            tick();
            low_cnt++;
        end
        send_frame(36, 40);
        check_frame("start_in_payload", 36, 32'hCBF4_3926);
        hi_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (eth_txen) hi_cnt++;
        end
        check_eq("no_second_frame", 64'(hi_cnt), 64'd0);
        check_eq("idle_at_end", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
